// File: rtl/tx_sr_ctrl.sv
// ---------------------------------------------------------------------------
// tx_sr_ctrl
//
// Frame controller for a downstream MSB-first parallel-to-serial (PTS) shift
// register that is NUM_BITS+1 wide and shifts in 1s. An accepted payload is
// sent as one start bit (0) followed by the data MSB first. A stop bit
// follows, made of the 1s shifted into the PTS. Each bit is held for
// BIT_PERIOD clocks.
//
// Parameters
//   NUM_BITS    payload width (>= 1)
//   BIT_PERIOD  clocks per serial bit (>= 2)
//
// Ports
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   tx_valid      upstream frame request
//   tx_data       upstream payload, sampled on accept
//   tx_abort      abort of the frame in flight, sampled on the clock edge
//   tx_ready      high only in IDLE: a frame can be accepted this cycle
//   load_enable   PTS parallel-load strobe
//   shift_enable  PTS shift strobe
//   pts_data      parallel word for the PTS. It is the frame word during a
//                 frame load and all ones otherwise.
//   tx_busy       a frame is in progress (LOAD, SHIFT, STOP)
//   frame_done    one-cycle pulse in the last STOP cycle of a completed frame
//
// Every output is a flop computed from the next-state values. The outputs
// therefore follow the registered state, and no input reaches an output
// within the same cycle. As a result, tx_abort takes effect on the cycle
// after it is sampled. That following cycle is the abort cycle, which reuses
// LOAD to load all ones into the PTS. The FSM then returns to IDLE.
// ---------------------------------------------------------------------------
module tx_sr_ctrl #(
    parameter int NUM_BITS   = 8,
    parameter int BIT_PERIOD = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                tx_valid,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_abort,
    output logic                tx_ready,
    output logic                load_enable,
    output logic                shift_enable,
    output logic [NUM_BITS:0]   pts_data,
    output logic                tx_busy,
    output logic                frame_done
);

    localparam int TW = $clog2(BIT_PERIOD);
    localparam int CW = $clog2(NUM_BITS + 2);

    localparam logic [TW-1:0]     TIMER_MAX = TW'(BIT_PERIOD - 1);
    // bit_cnt counts the shifts already taken. The final shift is the
    // (NUM_BITS+1)th shift, so it is taken while bit_cnt == NUM_BITS.
    localparam logic [CW-1:0]     LAST_BIT  = CW'(NUM_BITS);
    localparam logic [NUM_BITS:0] ALL_ONES  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e              state_q,  state_d;
    logic [TW-1:0]       timer_q,  timer_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [NUM_BITS:0]   frame_q,  frame_d;
    logic                abort_q,  abort_d;   // current LOAD is an abort cycle

    logic                tx_ready_q,     tx_ready_d;
    logic                tx_busy_q,      tx_busy_d;
    logic                load_enable_q,  load_enable_d;
    logic                shift_enable_q, shift_enable_d;
    logic                frame_done_q,   frame_done_d;
    logic [NUM_BITS:0]   pts_data_q,     pts_data_d;

    logic                abort_hit;

    // An abort stops a frame in LOAD, SHIFT or STOP. Once the final STOP
    // cycle shows frame_done, the frame has already completed and the line
    // is idle high. An abort sampled in that cycle has nothing left to stop,
    // so it is ignored. An abort that is sampled one cycle earlier replaces
    // the final STOP cycle, and no frame_done is produced.
    assign abort_hit = tx_abort && (state_q != IDLE)
                       && !((state_q == STOP) && (timer_q == TIMER_MAX));

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        abort_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // tx_abort has priority over tx_valid: no accept that cycle.
                if (tx_valid && !tx_abort) begin
                    frame_d   = {1'b0, tx_data};
                    state_d   = LOAD;
                    timer_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            LOAD: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                state_d   = abort_q ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (timer_q == TIMER_MAX) begin
                    timer_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == TIMER_MAX) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                timer_d   = '0;
                bit_cnt_d = '0;
            end
        endcase

        if (abort_hit) begin
            state_d   = LOAD;
            frame_d   = ALL_ONES;
            abort_d   = 1'b1;
            timer_d   = '0;
            bit_cnt_d = '0;
        end

        // The outputs are decoded from the next state. After the clock edge
        // they are a pure function of the registered state.
        tx_ready_d     = (state_d == IDLE);
        tx_busy_d      = (state_d != IDLE);
        load_enable_d  = (state_d == LOAD);
        shift_enable_d = (state_d == SHIFT) && (timer_d == TIMER_MAX);
        frame_done_d   = (state_d == STOP)  && (timer_d == TIMER_MAX);
        pts_data_d     = (state_d == LOAD) ? frame_d : ALL_ONES;
    end

    // NOTE: all control state, the frame register included, is reset. A reset
    // mid-frame must leave no stale frame or strobe behind.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            bit_cnt_q      <= '0;
            frame_q        <= ALL_ONES;
            abort_q        <= 1'b0;
            tx_ready_q     <= 1'b1;
            tx_busy_q      <= 1'b0;
            load_enable_q  <= 1'b0;
            shift_enable_q <= 1'b0;
            frame_done_q   <= 1'b0;
            pts_data_q     <= ALL_ONES;
        end else begin
            // NOTE: non-blocking assignments. Every flop samples the values
            // from before the edge, whatever the statement order.
            state_q        <= state_d;
            timer_q        <= timer_d;
            bit_cnt_q      <= bit_cnt_d;
            frame_q        <= frame_d;
            abort_q        <= abort_d;
            tx_ready_q     <= tx_ready_d;
            tx_busy_q      <= tx_busy_d;
            load_enable_q  <= load_enable_d;
            shift_enable_q <= shift_enable_d;
            frame_done_q   <= frame_done_d;
            pts_data_q     <= pts_data_d;
        end
    end

    assign tx_ready     = tx_ready_q;
    assign tx_busy      = tx_busy_q;
    assign load_enable  = load_enable_q;
    assign shift_enable = shift_enable_q;
    assign frame_done   = frame_done_q;
    assign pts_data     = pts_data_q;

endmodule
